// File: rtl/matmul_pkg.sv
// Shared types and geometry constants for the matmul tile sequencer.
package matmul_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int unsigned TILE_DIM       = 8;
  localparam int unsigned ELEM_BYTES     = 2;
  localparam int unsigned TILE_OUT_BYTES = TILE_DIM * TILE_DIM * ELEM_BYTES;
  // One 8-row panel of K elements is K * 16 bytes, so the stride is a shift.
  localparam int unsigned PANEL_SHIFT    = $clog2(TILE_DIM * ELEM_BYTES);

endpackage

// File: rtl/matmul_tile_sequencer_if.sv
// Host command/response and per-tile core command/response bundle.
interface matmul_tile_sequencer_if #(
  parameter int TILE_CNT_W = 16,
  parameter int ADDR_W     = 64,
  parameter int K_W        = 20
);
  logic                  cmd_0_valid;
  logic                  cmd_0_ready;
  logic [ADDR_W-1:0]     cmd_0_act_addr;
  logic [ADDR_W-1:0]     cmd_0_wgt_addr;
  logic [ADDR_W-1:0]     cmd_0_out_addr;
  logic [TILE_CNT_W-1:0] cmd_0_m_tiles;
  logic [TILE_CNT_W-1:0] cmd_0_n_tiles;
  logic [K_W-1:0]        cmd_0_inner_dimension;
  logic                  resp_0_valid;
  logic                  resp_0_ready;
  logic                  core_cmd_valid;
  logic                  core_cmd_ready;
  logic [ADDR_W-1:0]     core_cmd_act_addr;
  logic [ADDR_W-1:0]     core_cmd_wgt_addr;
  logic [ADDR_W-1:0]     core_cmd_out_addr;
  logic [K_W-1:0]        core_cmd_inner_dimension;
  logic                  core_resp_valid;
  logic                  core_resp_ready;

  // The sequencer itself is the slave side of this bundle.
  modport slave (
    input  cmd_0_valid, cmd_0_act_addr, cmd_0_wgt_addr, cmd_0_out_addr,
           cmd_0_m_tiles, cmd_0_n_tiles, cmd_0_inner_dimension,
           resp_0_ready, core_cmd_ready, core_resp_valid,
    output cmd_0_ready, resp_0_valid, core_cmd_valid, core_cmd_act_addr,
           core_cmd_wgt_addr, core_cmd_out_addr, core_cmd_inner_dimension,
           core_resp_ready
  );

  modport master (
    output cmd_0_valid, cmd_0_act_addr, cmd_0_wgt_addr, cmd_0_out_addr,
           cmd_0_m_tiles, cmd_0_n_tiles, cmd_0_inner_dimension,
           resp_0_ready, core_cmd_ready, core_resp_valid,
    input  cmd_0_ready, resp_0_valid, core_cmd_valid, core_cmd_act_addr,
           core_cmd_wgt_addr, core_cmd_out_addr, core_cmd_inner_dimension,
           core_resp_ready
  );
endinterface

// File: rtl/matmul_tile_sequencer_tile_addr_gen.sv
// Row-major tile walker: i/j counters plus incremental act/wgt/out address accumulators.
// Outputs are registered; load and advance take effect on the next clock.
module tile_addr_gen
  import matmul_pkg::*;
#(
  parameter int TILE_CNT_W = 16,
  parameter int ADDR_W     = 64,
  parameter int K_W        = 20
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  load,
  input  logic                  advance,
  input  logic [ADDR_W-1:0]     act_base_i,
  input  logic [ADDR_W-1:0]     wgt_base_i,
  input  logic [ADDR_W-1:0]     out_base_i,
  input  logic [TILE_CNT_W-1:0] m_tiles_i,
  input  logic [TILE_CNT_W-1:0] n_tiles_i,
  input  logic [K_W-1:0]        k_i,
  output logic [ADDR_W-1:0]     act_addr_o,
  output logic [ADDR_W-1:0]     wgt_addr_o,
  output logic [ADDR_W-1:0]     out_addr_o,
  output logic                  last_o
);

  logic [TILE_CNT_W-1:0] i_q, i_d, j_q, j_d, m_q, m_d, n_q, n_d;
  logic [ADDR_W-1:0]     act_q, act_d, wgt_q, wgt_d, out_q, out_d;
  logic [ADDR_W-1:0]     wgt_base_q, wgt_base_d, stride_q, stride_d;
  logic                  j_last;

  assign j_last     = (j_q == n_q - TILE_CNT_W'(1));
  assign last_o     = (i_q == m_q - TILE_CNT_W'(1)) && j_last;
  assign act_addr_o = act_q;
  assign wgt_addr_o = wgt_q;
  assign out_addr_o = out_q;

  always_comb begin
    i_d        = i_q;
    j_d        = j_q;
    m_d        = m_q;
    n_d        = n_q;
    act_d      = act_q;
    wgt_d      = wgt_q;
    out_d      = out_q;
    wgt_base_d = wgt_base_q;
    stride_d   = stride_q;
    if (load) begin
      i_d        = '0;
      j_d        = '0;
      m_d        = m_tiles_i;
      n_d        = n_tiles_i;
      act_d      = act_base_i;
      wgt_d      = wgt_base_i;
      out_d      = out_base_i;
      wgt_base_d = wgt_base_i;
      stride_d   = ADDR_W'(k_i) << PANEL_SHIFT;
    end else if (advance) begin
      out_d = out_q + ADDR_W'(TILE_OUT_BYTES);
      if (j_last) begin
        j_d   = '0;
        wgt_d = wgt_base_q;
        act_d = act_q + stride_q;
        i_d   = i_q + TILE_CNT_W'(1);
      end else begin
        j_d   = j_q + TILE_CNT_W'(1);
        wgt_d = wgt_q + stride_q;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      i_q        <= '0;
      j_q        <= '0;
      m_q        <= '0;
      n_q        <= '0;
      act_q      <= '0;
      wgt_q      <= '0;
      out_q      <= '0;
      wgt_base_q <= '0;
      stride_q   <= '0;
    end else begin
      i_q        <= i_d;
      j_q        <= j_d;
      m_q        <= m_d;
      n_q        <= n_d;
      act_q      <= act_d;
      wgt_q      <= wgt_d;
      out_q      <= out_d;
      wgt_base_q <= wgt_base_d;
      stride_q   <= stride_d;
    end
  end

endmodule

// File: rtl/matmul_tile_sequencer.sv
// Splits one MxN-tile matmul command into per-tile core commands, one outstanding at a time.
// Host fire -> core cmd next cycle; last core resp -> host resp next cycle; all handshakes stall on ready.
module matmul_tile_sequencer
  import matmul_pkg::*;
#(
  parameter int TILE_CNT_W = 16,
  parameter int ADDR_W     = 64,
  parameter int K_W        = 20
) (
  input  logic                      clock,
  input  logic                      reset,
  matmul_tile_sequencer_if.slave    bus,
  output logic                      busy,
  output logic [2*TILE_CNT_W-1:0]   tiles_done
);

  state_e                  state_q, state_d;
  logic [K_W-1:0]          k_q, k_d;
  logic [2*TILE_CNT_W-1:0] tiles_done_q, tiles_done_d;
  logic                    load, advance, last;
  logic                    cmd_ready, resp_valid, core_valid, core_resp_rdy;
  logic                    zero_size;

  assign zero_size = (bus.cmd_0_m_tiles == '0) || (bus.cmd_0_n_tiles == '0) ||
                     (bus.cmd_0_inner_dimension == '0);

  tile_addr_gen #(
    .TILE_CNT_W(TILE_CNT_W),
    .ADDR_W    (ADDR_W),
    .K_W       (K_W)
  ) u_addr_gen (
    .clock     (clock),
    .reset     (reset),
    .load      (load),
    .advance   (advance),
    .act_base_i(bus.cmd_0_act_addr),
    .wgt_base_i(bus.cmd_0_wgt_addr),
    .out_base_i(bus.cmd_0_out_addr),
    .m_tiles_i (bus.cmd_0_m_tiles),
    .n_tiles_i (bus.cmd_0_n_tiles),
    .k_i       (bus.cmd_0_inner_dimension),
    .act_addr_o(bus.core_cmd_act_addr),
    .wgt_addr_o(bus.core_cmd_wgt_addr),
    .out_addr_o(bus.core_cmd_out_addr),
    .last_o    (last)
  );

  always_comb begin
    state_d       = state_q;
    cmd_ready     = 1'b0;
    resp_valid    = 1'b0;
    core_valid    = 1'b0;
    core_resp_rdy = 1'b0;
    load          = 1'b0;
    advance       = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cmd_ready = 1'b1;
        if (bus.cmd_0_valid) begin
          load    = 1'b1;
          state_d = zero_size ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        core_valid = 1'b1;
        if (bus.core_cmd_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        core_resp_rdy = 1'b1;
        if (bus.core_resp_valid) begin
          advance = 1'b1;
          state_d = last ? ST_DONE : ST_ISSUE;
        end
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        if (bus.resp_0_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    k_d          = load ? bus.cmd_0_inner_dimension : k_q;
    tiles_done_d = tiles_done_q;
    if (load)         tiles_done_d = '0;
    else if (advance) tiles_done_d = tiles_done_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      k_q          <= '0;
      tiles_done_q <= '0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      tiles_done_q <= tiles_done_d;
    end
  end

  assign bus.cmd_0_ready              = cmd_ready;
  assign bus.resp_0_valid             = resp_valid;
  assign bus.core_cmd_valid           = core_valid;
  assign bus.core_resp_ready          = core_resp_rdy;
  assign bus.core_cmd_inner_dimension = k_q;
  assign busy                         = (state_q != ST_IDLE);
  assign tiles_done                   = tiles_done_q;

endmodule

// File: tb/tb_matmul_tile_sequencer.sv
// Directed bench for matmul_tile_sequencer: tile order, zero-size, backpressure, spurious resp, reset, wrap.
module tb_matmul_tile_sequencer;

  logic        clock = 1'b0;
  logic        reset;
  logic        busy;
  logic [31:0] tiles_done;
  int          tests = 0;
  int          fails = 0;

  always #5 clock = ~clock;

  matmul_tile_sequencer_if #(.TILE_CNT_W(16), .ADDR_W(64), .K_W(20)) bus ();

  matmul_tile_sequencer #(.TILE_CNT_W(16), .ADDR_W(64), .K_W(20)) dut (
    .clock     (clock),
    .reset     (reset),
    .bus       (bus.slave),
    .busy      (busy),
    .tiles_done(tiles_done)
  );

  logic [63:0] exp_act [6] = '{64'h1000, 64'h1000, 64'h1000, 64'h1040, 64'h1040, 64'h1040};
  logic [63:0] exp_wgt [6] = '{64'h2000, 64'h2040, 64'h2080, 64'h2000, 64'h2040, 64'h2080};
  logic [63:0] exp_out [6] = '{64'h3000, 64'h3080, 64'h3100, 64'h3180, 64'h3200, 64'h3280};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_cmd(input logic [63:0] act, input logic [63:0] wgt, input logic [63:0] out,
                          input logic [15:0] m, input logic [15:0] n, input logic [19:0] k);
    bus.cmd_0_act_addr        = act;
    bus.cmd_0_wgt_addr        = wgt;
    bus.cmd_0_out_addr        = out;
    bus.cmd_0_m_tiles         = m;
    bus.cmd_0_n_tiles         = n;
    bus.cmd_0_inner_dimension = k;
    bus.cmd_0_valid           = 1'b1;
    check("cmd_ready_idle", bus.cmd_0_ready, 1);
    tick();
    bus.cmd_0_valid = 1'b0;
  endtask

  // Expects core_cmd_valid already high; holds ready low for 'hold' cycles, then fires cmd and resp.
  task automatic serve_tile(input string tag, input logic [63:0] ea, input logic [63:0] ew,
                            input logic [63:0] eo, input int hold);
    check({tag, "_vld"}, bus.core_cmd_valid, 1);
    check({tag, "_act"}, bus.core_cmd_act_addr, ea);
    check({tag, "_wgt"}, bus.core_cmd_wgt_addr, ew);
    check({tag, "_out"}, bus.core_cmd_out_addr, eo);
    for (int c = 0; c < hold; c++) begin
      tick();
      check({tag, "_hold_vld"}, bus.core_cmd_valid, 1);
      check({tag, "_hold_act"}, bus.core_cmd_act_addr, ea);
      check({tag, "_hold_wgt"}, bus.core_cmd_wgt_addr, ew);
      check({tag, "_hold_out"}, bus.core_cmd_out_addr, eo);
    end
    bus.core_cmd_ready = 1'b1;
    tick();
    bus.core_cmd_ready = 1'b0;
    check({tag, "_wait_vld"}, bus.core_cmd_valid, 0);
    check({tag, "_wait_rrdy"}, bus.core_resp_ready, 1);
    check({tag, "_wait_cmdrdy"}, bus.cmd_0_ready, 0);
    bus.core_resp_valid = 1'b1;
    tick();
    bus.core_resp_valid = 1'b0;
  endtask

  task automatic finish_resp(input string tag, input logic [31:0] exp_done);
    check({tag, "_resp_vld"}, bus.resp_0_valid, 1);
    check({tag, "_tiles_done"}, tiles_done, exp_done);
    check({tag, "_no_core_cmd"}, bus.core_cmd_valid, 0);
    bus.resp_0_ready = 1'b1;
    tick();
    bus.resp_0_ready = 1'b0;
    check({tag, "_idle_busy"}, busy, 0);
    check({tag, "_idle_resp"}, bus.resp_0_valid, 0);
  endtask

  initial begin
    reset                     = 1'b1;
    bus.cmd_0_valid           = 1'b0;
    bus.cmd_0_act_addr        = '0;
    bus.cmd_0_wgt_addr        = '0;
    bus.cmd_0_out_addr        = '0;
    bus.cmd_0_m_tiles         = '0;
    bus.cmd_0_n_tiles         = '0;
    bus.cmd_0_inner_dimension = '0;
    bus.resp_0_ready          = 1'b0;
    bus.core_cmd_ready        = 1'b0;
    bus.core_resp_valid       = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    check("rst_busy", busy, 0);
    check("rst_core_vld", bus.core_cmd_valid, 0);
    check("rst_resp_vld", bus.resp_0_valid, 0);
    check("rst_core_rrdy", bus.core_resp_ready, 0);
    check("rst_tiles_done", tiles_done, 0);
    check("rst_act", bus.core_cmd_act_addr, 0);
    check("rst_cmd_rdy", bus.cmd_0_ready, 1);

    // 2x3 tiles, K=4: stride 0x40; tile 1 backpressured, spurious resp during tile 2 ISSUE
    send_cmd(64'h1000, 64'h2000, 64'h3000, 16'd2, 16'd3, 20'd4);
    check("t1_k", bus.core_cmd_inner_dimension, 4);
    check("t1_busy", busy, 1);
    for (int t = 0; t < 6; t++) begin
      if (t == 2) begin
        bus.core_resp_valid = 1'b1;
        check("spur_issue_rrdy", bus.core_resp_ready, 0);
        tick();
        bus.core_resp_valid = 1'b0;
        check("spur_issue_done", tiles_done, 2);
      end
      serve_tile($sformatf("t1_tile%0d", t), exp_act[t], exp_wgt[t], exp_out[t], (t == 1) ? 5 : 0);
    end
    for (int c = 0; c < 3; c++) begin
      check("t1_resp_hold", bus.resp_0_valid, 1);
      check("t1_resp_hold_done", tiles_done, 6);
      tick();
    end
    finish_resp("t1", 32'd6);
    check("t1_done_kept", tiles_done, 6);

    bus.core_resp_valid = 1'b1;
    check("spur_idle_rrdy", bus.core_resp_ready, 0);
    tick();
    bus.core_resp_valid = 1'b0;
    check("spur_idle_busy", busy, 0);
    check("spur_idle_done", tiles_done, 6);

    // Zero-size commands: M=0, N=0, K=0
    send_cmd(64'h1000, 64'h2000, 64'h3000, 16'd0, 16'd2, 20'd4);
    finish_resp("zero_m", 32'd0);
    send_cmd(64'h1000, 64'h2000, 64'h3000, 16'd2, 16'd0, 20'd4);
    finish_resp("zero_n", 32'd0);
    send_cmd(64'h1000, 64'h2000, 64'h3000, 16'd2, 16'd2, 20'd0);
    finish_resp("zero_k", 32'd0);

    // Reset after the 2nd core response of a 4x4 command
    send_cmd(64'h1000, 64'h2000, 64'h3000, 16'd4, 16'd4, 20'd4);
    serve_tile("r_tile0", 64'h1000, 64'h2000, 64'h3000, 0);
    serve_tile("r_tile1", 64'h1000, 64'h2040, 64'h3080, 0);
    check("r_mid_done", tiles_done, 2);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("r_busy", busy, 0);
    check("r_core_vld", bus.core_cmd_valid, 0);
    check("r_resp_vld", bus.resp_0_valid, 0);
    check("r_core_rrdy", bus.core_resp_ready, 0);
    check("r_tiles_done", tiles_done, 0);
    check("r_act", bus.core_cmd_act_addr, 0);
    check("r_out", bus.core_cmd_out_addr, 0);
    tick();
    check("r_quiet_vld", bus.core_cmd_valid, 0);
    check("r_quiet_resp", bus.resp_0_valid, 0);
    send_cmd(64'h5000, 64'h6000, 64'h0, 16'd1, 16'd1, 20'd1);
    serve_tile("r1x1", 64'h5000, 64'h6000, 64'h0, 0);
    finish_resp("r1x1", 32'd1);

    // Activation address wraps past 2^64
    send_cmd(64'hFFFF_FFFF_FFFF_FFC0, 64'h100, 64'h200, 16'd2, 16'd1, 20'd4);
    serve_tile("wrap0", 64'hFFFF_FFFF_FFFF_FFC0, 64'h100, 64'h200, 0);
    serve_tile("wrap1", 64'h0, 64'h100, 64'h280, 0);
    finish_resp("wrap", 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
